axon_delay_line: RTL and testbench

AXON_DELAY_LINE -- requirements
Module: axon_delay_line

---
 rtl/neuron_pkg.sv | 17 +
 rtl/spike_fifo.sv | 63 ++++++
 rtl/axon_delay_line.sv | 136 +++++++++++++
 tb/tb_axon_delay_line.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared neuron definitions: lifecycle states and default timestamp width.
// Used by the soma and by the axon delay line.
package neuron_pkg;

  // RUN: accepting and emitting spikes. DEAD: flushed and idle until reset.
  typedef enum logic {
    RUN  = 1'b0,
    DEAD = 1'b1
  } neuron_state_e;

  // Default width of timestamps, delays and the global time counter.
  localparam int NEURON_TW = 8;

  // Width of the source id attached to emitted spikes.
  localparam int NEURON_ID_W = 8;

endpackage : neuron_pkg

// File: rtl/spike_fifo.sv
// Plain FIFO of pending spike due-times.
// A push while full and a pop while empty are both ignored.
// clr empties the queue synchronously and has priority over push/pop.
module spike_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage array: data only, no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : spike_fifo

// File: rtl/axon_delay_line.sv
// Axon delay line: queues spikes from the soma, holds each one until its
// arrival time (fire time + configured delay) is reached on the global time
// counter, then presents it to the router through a registered output stage.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A valid source holds valid and its payload steady until that
// edge. in_ready is combinational from state and queue occupancy only, never
// from in_valid. out_valid/out_time come straight from registers.
module axon_delay_line
  import neuron_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter int         TW        = NEURON_TW,
  parameter logic [7:0] NEURON_ID = 8'd0,
  localparam int        CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          kill,
  input  logic          cfg_we,
  input  logic [TW-1:0] axon_delay,
  input  logic          tick,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [TW-1:0] in_time,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] out_time,
  output logic [7:0]    out_id,
  output logic [CW-1:0] count,
  output logic          dbg_state
);

  neuron_state_e state_q, state_d;
  logic [TW-1:0] now_q;
  logic [TW-1:0] delay_q;
  logic          out_valid_q, out_valid_d;
  logic [TW-1:0] out_time_q, out_time_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [TW-1:0] head_time;
  logic [TW-1:0] due_in;
  logic [TW-1:0] age;
  logic          head_due;
  logic          kill_now;
  logic          run_ok;
  logic          push;
  logic          pop;
  logic          out_load;
  logic          cfg_ok;

  // Kill only matters while running; once dead the block is inert until rst.
  assign kill_now = (state_q == RUN) && kill;
  assign run_ok   = (state_q == RUN) && !kill;

  assign in_ready = (state_q == RUN) && !fifo_full;
  assign push     = in_valid && in_ready && !kill;
  assign due_in   = in_time + delay_q;

  // Serial-number comparison: head is due once now is at most half the
  // counter range past it, which tolerates wrap of the time counter.
  assign age      = now_q - head_time;
  assign head_due = !fifo_empty && !age[TW-1];

  // Output register may take a new spike when empty or when being consumed.
  assign out_load = run_ok && (!out_valid_q || out_ready);
  assign pop      = out_load && head_due;

  // Delay is only changed while nothing is in flight, so FIFO order stays
  // equal to due-time order.
  assign cfg_ok   = cfg_we && fifo_empty && !out_valid_q;

  assign out_valid = out_valid_q;
  assign out_time  = out_time_q;
  assign out_id    = NEURON_ID;
  assign count     = fifo_count;
  assign dbg_state = state_q;

  spike_fifo #(
    .DEPTH (DEPTH),
    .W     (TW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (kill_now),
    .push  (push),
    .pop   (pop),
    .din   (due_in),
    .dout  (head_time),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Lifecycle next state: RUN falls to DEAD on kill, DEAD is sticky.
  always_comb begin
    state_d = state_q;
    if (kill_now) begin
      state_d = DEAD;
    end
  end

  // Output stage next state: flush on kill, otherwise refill when allowed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_time_d  = out_time_q;
    if (kill_now) begin
      out_valid_d = 1'b0;
    end else if (out_load) begin
      out_valid_d = head_due;
      if (head_due) begin
        out_time_d = head_time;
      end
    end
  end

  // State, time counter, delay register and output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      now_q       <= '0;
      delay_q     <= '0;
      out_valid_q <= 1'b0;
      out_time_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_time_q  <= out_time_d;
      if (tick)   now_q   <= now_q + 1'b1;
      if (cfg_ok) delay_q <= axon_delay;
    end
  end

endmodule : axon_delay_line

// File: tb/tb_axon_delay_line.sv
// Directed bench for axon_delay_line with an arrival-time scoreboard.
module tb_axon_delay_line;

  logic       clk;
  logic       rst;
  logic       kill;
  logic       cfg_we;
  logic [7:0] axon_delay;
  logic       tick;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_time;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_time;
  logic [7:0] out_id;
  logic [3:0] count;
  logic       dbg_state;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] exp_q[$];
  logic [7:0] d_m = 8'd0;

  axon_delay_line #(
    .DEPTH     (8),
    .TW        (8),
    .NEURON_ID (8'h5A)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .kill       (kill),
    .cfg_we     (cfg_we),
    .axon_delay (axon_delay),
    .tick       (tick),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_time    (in_time),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_time   (out_time),
    .out_id     (out_id),
    .count      (count),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: observed=hang required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: handshakes are observed mid-cycle, before the edge that commits them.
  always @(negedge clk) begin
    if (!rst) begin
      if (kill) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_emit", {24'd0, out_time}, 32'hFFFF_FFFF);
          end else begin
            chk("emit_time", {24'd0, out_time}, {24'd0, exp_q.pop_front()});
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(in_time + d_m);
        end
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    cyc(n);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    kill       = 1'b0;
    cfg_we     = 1'b0;
    axon_delay = 8'd0;
    tick       = 1'b0;
    in_valid   = 1'b0;
    in_time    = 8'd0;
    out_ready  = 1'b0;
    exp_q.delete();
    d_m = 8'd0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic set_delay(input logic [7:0] d);
    cfg_we     = 1'b1;
    axon_delay = d;
    cyc(1);
    cfg_we = 1'b0;
    d_m    = d;
  endtask

  task automatic offer(input logic [7:0] t);
    int k = 0;
    in_valid = 1'b1;
    in_time  = t;
    while (!in_ready && k < 50) begin
      cyc(1);
      k++;
    end
    chk("offer_accept_in_time", {31'd0, (k < 50)}, 32'd1);
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int k = 0;
    while ((count != 0 || out_valid) && k < maxc) begin
      cyc(1);
      k++;
    end
    chk("drain_in_time", {31'd0, (k < maxc)}, 32'd1);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count",     {28'd0, count},     32'd0);
    chk("rst_out_time",  {24'd0, out_time},  32'd0);
    chk("rst_out_id",    {24'd0, out_id},    32'h5A);
    chk("rst_state",     {31'd0, dbg_state}, 32'd0);

    // Zero delay, minimum latency
    set_delay(8'd0);
    ticks(5);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_time   = 8'd5;
    cyc(1);
    in_valid = 1'b0;
    chk("lat_e_out_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_e_count",     {28'd0, count},     32'd1);
    cyc(1);
    chk("lat_e1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_e1_out_time",  {24'd0, out_time},  32'd5);
    chk("lat_e1_count",     {28'd0, count},     32'd0);
    cyc(1);
    chk("lat_done_out_valid", {31'd0, out_valid}, 32'd0);

    // Delay 3 from now=10
    do_reset();
    set_delay(8'd3);
    ticks(10);
    out_ready = 1'b1;
    offer(8'd10);
    chk("d3_count",     {28'd0, count},     32'd1);
    chk("d3_not_yet_0", {31'd0, out_valid}, 32'd0);
    ticks(2);
    chk("d3_not_yet_2", {31'd0, out_valid}, 32'd0);
    ticks(1);
    chk("d3_not_yet_3", {31'd0, out_valid}, 32'd0);
    cyc(1);
    chk("d3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("d3_out_time",  {24'd0, out_time},  32'd13);
    cyc(1);

    // Arrival time across counter wrap
    do_reset();
    set_delay(8'd4);
    ticks(254);
    out_ready = 1'b1;
    offer(8'd254);
    cyc(2);
    chk("wrap_hold_254", {31'd0, out_valid}, 32'd0);
    chk("wrap_count",    {28'd0, count},     32'd1);
    ticks(3);
    cyc(1);
    chk("wrap_hold_1", {31'd0, out_valid}, 32'd0);
    ticks(1);
    cyc(1);
    chk("wrap_out_valid", {31'd0, out_valid}, 32'd1);
    chk("wrap_out_time",  {24'd0, out_time},  32'd2);
    cyc(1);

    // Fill to capacity with back-pressure, then drain back-to-back
    do_reset();
    set_delay(8'd0);
    ticks(20);
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_time  = 8'(11 + i);
      cyc(1);
    end
    in_valid = 1'b0;
    chk("full_count",     {28'd0, count},     32'd8);
    chk("full_in_ready",  {31'd0, in_ready},  32'd0);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("full_out_time",  {24'd0, out_time},  32'd11);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_out_time",  {24'd0, out_time},  32'(11 + i));
      cyc(1);
    end
    chk("b2b_end_out_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_end_count",     {28'd0, count},     32'd0);

    // Asynchronous reset mid-operation drops pending spikes
    do_reset();
    out_ready = 1'b0;
    offer(8'd0);
    offer(8'd0);
    offer(8'd0);
    chk("mid_pre_count", {28'd0, count}, 32'd2);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_count",     {28'd0, count},     32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    cyc(3);
    chk("mid_after_out_valid", {31'd0, out_valid}, 32'd0);

    // Kill with pending entries and a simultaneous offer
    do_reset();
    set_delay(8'd5);
    out_ready = 1'b1;
    offer(8'd0);
    offer(8'd0);
    offer(8'd1);
    chk("kill_pre_count", {28'd0, count}, 32'd3);
    kill     = 1'b1;
    in_valid = 1'b1;
    in_time  = 8'd2;
    cyc(1);
    chk("kill_count",     {28'd0, count},     32'd0);
    chk("kill_out_valid", {31'd0, out_valid}, 32'd0);
    chk("kill_in_ready",  {31'd0, in_ready},  32'd0);
    chk("kill_state",     {31'd0, dbg_state}, 32'd1);
    kill = 1'b0;
    ticks(10);
    chk("dead_in_ready",  {31'd0, in_ready},  32'd0);
    chk("dead_count",     {28'd0, count},     32'd0);
    chk("dead_out_valid", {31'd0, out_valid}, 32'd0);
    chk("dead_state",     {31'd0, dbg_state}, 32'd1);
    in_valid = 1'b0;
    do_reset();
    chk("revive_state",    {31'd0, dbg_state}, 32'd0);
    chk("revive_in_ready", {31'd0, in_ready},  32'd1);

    // Delay reconfiguration only when idle
    set_delay(8'd2);
    out_ready = 1'b0;
    offer(8'd0);
    offer(8'd0);
    chk("cfg_busy_count", {28'd0, count}, 32'd2);
    cfg_we     = 1'b1;
    axon_delay = 8'd9;
    cyc(1);
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    ticks(2);
    wait_drain(20);
    set_delay(8'd9);
    offer(8'd2);
    ticks(9);
    cyc(1);
    chk("cfg_new_out_valid", {31'd0, out_valid}, 32'd1);
    chk("cfg_new_out_time",  {24'd0, out_time},  32'd11);
    cyc(2);

    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule : tb_axon_delay_line
